// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared types and constants for the instruction-memory boot loader
//   boot_state_e  : loader FSM states
//   HALT_WORD_DEF : default end-of-program marker
//   BYTE_W, LANES : byte-lane width and lanes per instruction word
package boot_pkg;
    typedef enum logic [2:0] {ST_LOAD, ST_WRITE, ST_HOLD, ST_RUN, ST_ERROR} boot_state_e;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam int BYTE_W = 8;
    localparam int LANES = 4;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream, instruction-memory and core-control bundle of the boot loader
//   master : loader side (consumes rx bytes, drives memory write and core control)
//   slave  : environment side (byte source, memory, core)
interface boot_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              cpu_enable;
    logic              load_done;
    logic              error;
    logic [ADDR_W:0]   word_count;
    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output cpu_rst, cpu_enable, load_done, error, word_count
    );
    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_rst, cpu_enable, load_done, error, word_count
    );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// boot_word_packer: assembles four accepted bytes into a little-endian 32-bit word
//   clk          : clock
//   clear_i      : synchronous clear of byte index and word
//   accept_i     : byte accepted this cycle
//   data_i       : byte value
//   word_ready_o : the byte accepted this cycle completes the word
//   word_o       : assembled word (registered)
module boot_word_packer
    import boot_pkg::*;
(
    input  logic                      clk,
    input  logic                      clear_i,
    input  logic                      accept_i,
    input  logic [BYTE_W-1:0]         data_i,
    output logic                      word_ready_o,
    output logic [LANES*BYTE_W-1:0]   word_o
);
    logic [1:0]                idx_q;
    logic [LANES*BYTE_W-1:0]   word_q;
    always_ff @(posedge clk) begin
        if (clear_i) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else if (accept_i) begin
            word_q[BYTE_W*idx_q +: BYTE_W] <= data_i;
            idx_q <= idx_q + 2'd1;
        end
    end
    // the 2-bit index wraps to lane 0 by itself after the last lane
    assign word_ready_o = accept_i && (idx_q == 2'd3);
    assign word_o       = word_q;
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a byte stream into instruction memory, then releases the core
//   clk : clock
//   rst : synchronous reset, active low
//   bus : boot_if.master (rx byte handshake, imem write port, core reset/enable, status)
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter int          RST_CYCLES = 4,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEF
) (
    input logic    clk,
    input logic    rst,
    boot_if.master bus
);
    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    boot_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   word_count_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rx_ready_q;
    logic              imem_we_q;
    logic              cpu_rst_q;
    logic              cpu_enable_q;
    logic              load_done_q;
    logic              error_q;
    logic              accept;
    logic              word_ready;
    logic [31:0]       word;
    // rx_ready_q is only ever high in LOAD, so it alone qualifies acceptance
    assign accept = bus.rx_valid && rx_ready_q;
    boot_word_packer u_packer (
        .clk          (clk),
        .clear_i      (!rst),
        .accept_i     (accept),
        .data_i       (bus.rx_data),
        .word_ready_o (word_ready),
        .word_o       (word)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            addr_q       <= '0;
            word_count_q <= '0;
            cnt_q        <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            cpu_rst_q    <= 1'b1;
            cpu_enable_q <= 1'b0;
            load_done_q  <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    rx_ready_q <= !word_ready;
                    if (word_ready) begin
                        state_q   <= ST_WRITE;
                        imem_we_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    imem_we_q    <= 1'b0;
                    word_count_q <= word_count_q + 1'b1;
                    if (word == HALT_WORD) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                    end else if (addr_q == {ADDR_W{1'b1}}) begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                    end else begin
                        state_q    <= ST_LOAD;
                        addr_q     <= addr_q + 1'b1;
                        rx_ready_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_q      <= ST_RUN;
                        cpu_rst_q    <= 1'b0;
                        cpu_enable_q <= 1'b1;
                        load_done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    // RUN and ERROR are terminal; only rst leaves them
                end
            endcase
        end
    end
    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.cpu_enable = cpu_enable_q;
    assign bus.load_done  = load_done_q;
    assign bus.error      = error_q;
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: self-checking bench for imem_boot_loader (default and ADDR_W=2 instances)
module tb_imem_boot_loader;
    typedef struct {
        logic [7:0]  bs [4];
        int          gap;
        logic [7:0]  ea;
        logic [31:0] ed;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        vld = 1'b0;
    logic [7:0]  dat = 8'h00;
    logic        rdy;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fall_cyc = -1;
    int          en_cyc = -1;
    int          done_cyc = -1;
    int          last_we = -1;
    int          we_rdy_bad = 0;
    logic [39:0] wr_a [$];
    logic [33:0] wr_b [$];
    vec_t        tab [6];
    always #5 clk = ~clk;
    boot_if #(.ADDR_W(8)) a ();
    boot_if #(.ADDR_W(2)) b ();
    assign a.rx_valid = vld && !sel;
    assign b.rx_valid = vld && sel;
    assign a.rx_data  = dat;
    assign b.rx_data  = dat;
    assign rdy        = sel ? b.rx_ready : a.rx_ready;
    imem_boot_loader #(.ADDR_W(8), .RST_CYCLES(4)) dut_a (.clk(clk), .rst(rst), .bus(a));
    imem_boot_loader #(.ADDR_W(2), .RST_CYCLES(4)) dut_b (.clk(clk), .rst(rst), .bus(b));
    // monitor: records every write cycle and the first cycle of each core-release signal
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            wr_a.delete();
            wr_b.delete();
            fall_cyc = -1;
            en_cyc = -1;
            done_cyc = -1;
            last_we = -1;
            we_rdy_bad = 0;
        end else begin
            if (a.imem_we) begin
                wr_a.push_back({a.imem_addr, a.imem_wdata});
                last_we = cyc;
                if (a.rx_ready) we_rdy_bad++;
            end
            if (b.imem_we) wr_b.push_back({b.imem_addr, b.imem_wdata});
            if (!a.cpu_rst && fall_cyc < 0) fall_cyc = cyc;
            if (a.cpu_enable && en_cyc < 0) en_cyc = cyc;
            if (a.load_done && done_cyc < 0) done_cyc = cyc;
        end
    end
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic set_vec(input int i, input logic [7:0] b0, b1, b2, b3, input int gap,
                           input logic [7:0] ea, input logic [31:0] ed);
        tab[i].bs[0] = b0;
        tab[i].bs[1] = b1;
        tab[i].bs[2] = b2;
        tab[i].bs[3] = b3;
        tab[i].gap = gap;
        tab[i].ea = ea;
        tab[i].ed = ed;
    endtask
    task automatic do_reset(input bit check_vals);
        rst = 1'b0;
        vld = 1'b0;
        @(negedge clk);
        if (check_vals) begin
            chk("rst_rx_ready", a.rx_ready, 0);
            chk("rst_imem_we", a.imem_we, 0);
            chk("rst_imem_addr", a.imem_addr, 0);
            chk("rst_imem_wdata", a.imem_wdata, 0);
            chk("rst_cpu_rst", a.cpu_rst, 1);
            chk("rst_cpu_enable", a.cpu_enable, 0);
            chk("rst_load_done", a.load_done, 0);
            chk("rst_error", a.error, 0);
            chk("rst_word_count", a.word_count, 0);
        end
        rst = 1'b1;
    endtask
    // called at a negedge; returns at the negedge following the accepting edge
    task automatic send_byte(input logic [7:0] v, input int gap);
        if (gap > 0) begin
            vld = 1'b0;
            repeat (gap) @(negedge clk);
        end
        vld = 1'b1;
        dat = v;
        for (int t = 0; t < 40; t++) begin
            if (rdy) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte %02h not accepted within 40 cycles", v);
    endtask
    task automatic send_word(input logic [31:0] w, input int gap);
        for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], gap);
    endtask
    task automatic wait_done();
        for (int t = 0; t < 80; t++) begin
            if (a.load_done) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL load_done_timeout: load_done still 0 after 80 cycles");
    endtask
    task automatic exp_write_a(input logic [7:0] ad, input logic [31:0] d);
        logic [39:0] e;
        if (wr_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_missing: no write seen, expected addr %0h data %08h", ad, d);
        end else begin
            e = wr_a.pop_front();
            chk("write_addr", e[39:32], ad);
            chk("write_data", e[31:0], d);
        end
    endtask
    initial begin
        logic [7:0]  q [$];
        logic [31:0] w;
        logic [33:0] eb;
        int          n;
        int          rdy_hi;
        set_vec(0, 8'h13, 8'h00, 8'h10, 8'h00, 0, 8'd0, 32'h0010_0013);
        set_vec(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 8'd1, 32'hFFFF_FFFF);
        set_vec(2, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 1, 8'd0, 32'hDEAD_BEEF);
        set_vec(3, 8'h78, 8'h56, 8'h34, 8'h12, 3, 8'd1, 32'h1234_5678);
        set_vec(4, 8'h01, 8'h02, 8'h03, 8'h04, 2, 8'd2, 32'h0403_0201);
        set_vec(5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 8'd3, 32'hFFFF_FFFF);
        do_reset(1);
        // back-to-back program: one instruction plus halt
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) send_byte(tab[i].bs[j], tab[i].gap);
        vld = 1'b0;
        wait_done();
        for (int i = 0; i < 2; i++) exp_write_a(tab[i].ea, tab[i].ed);
        chk("t1_word_count", a.word_count, 2);
        chk("t1_release_delay", fall_cyc - last_we, 5);
        chk("t1_enable_with_release", en_cyc, fall_cyc);
        chk("t1_done_with_release", done_cyc, fall_cyc);
        // RUN ignores incoming bytes
        rdy_hi = 0;
        for (int t = 0; t < 20; t++) begin
            vld = 1'b1;
            dat = 8'($urandom);
            if (rdy) rdy_hi++;
            @(negedge clk);
        end
        vld = 1'b0;
        chk("run_rx_ready_cycles", rdy_hi, 0);
        chk("run_writes", wr_a.size(), 0);
        chk("run_addr", a.imem_addr, 1);
        chk("run_wdata", a.imem_wdata, 32'hFFFF_FFFF);
        chk("run_word_count", a.word_count, 2);
        chk("run_cpu_rst", a.cpu_rst, 0);
        chk("run_cpu_enable", a.cpu_enable, 1);
        // reset while running puts the core straight back in reset
        rst = 1'b0;
        @(negedge clk);
        chk("runrst_cpu_enable", a.cpu_enable, 0);
        chk("runrst_cpu_rst", a.cpu_rst, 1);
        chk("runrst_load_done", a.load_done, 0);
        chk("runrst_word_count", a.word_count, 0);
        rst = 1'b1;
        send_word(32'hCAFE_BABE, 0);
        send_word(32'hFFFF_FFFF, 1);
        vld = 1'b0;
        wait_done();
        exp_write_a(8'd0, 32'hCAFE_BABE);
        exp_write_a(8'd1, 32'hFFFF_FFFF);
        // irregular valid with gaps 0..3, valid held through the write bubble
        do_reset(0);
        for (int i = 2; i < 6; i++)
            for (int j = 0; j < 4; j++) send_byte(tab[i].bs[j], (tab[i].gap + j) % 4);
        vld = 1'b0;
        wait_done();
        for (int i = 2; i < 6; i++) exp_write_a(tab[i].ea, tab[i].ed);
        chk("irr_ready_in_write", we_rdy_bad, 0);
        chk("irr_word_count", a.word_count, 4);
        // random programs against a byte-level reference model
        for (int r = 0; r < 4; r++) begin
            do_reset(0);
            q.delete();
            n = $urandom_range(2, 8);
            for (int k = 0; k < 4 * n; k++)
                q.push_back((k % 4 == 0) ? 8'($urandom_range(0, 254)) : 8'($urandom_range(0, 255)));
            for (int k = 0; k < 4; k++) q.push_back(8'hFF);
            foreach (q[k]) send_byte(q[k], $urandom_range(0, 3));
            vld = 1'b0;
            wait_done();
            for (int i = 0; i < q.size() / 4; i++) begin
                w = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
                exp_write_a(8'(i), w);
            end
            chk("rnd_word_count", a.word_count, n + 1);
            chk("rnd_error", a.error, 0);
            chk("rnd_ready_in_write", we_rdy_bad, 0);
        end
        // ADDR_W=2: memory fills without a halt word
        sel = 1'b1;
        do_reset(0);
        for (int i = 1; i <= 4; i++) send_word(32'(i), 0);
        chk("full_last_we", b.imem_we, 1);
        chk("full_error_during_write", b.error, 0);
        vld = 1'b0;
        @(negedge clk);
        chk("full_error", b.error, 1);
        chk("full_rx_ready", b.rx_ready, 0);
        chk("full_cpu_rst", b.cpu_rst, 1);
        for (int i = 0; i < 4; i++) begin
            if (wr_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL full_write_missing: no write seen, expected addr %0d", i);
            end else begin
                eb = wr_b.pop_front();
                chk("full_write_addr", eb[33:32], i);
                chk("full_write_data", eb[31:0], i + 1);
            end
        end
        for (int t = 0; t < 12; t++) begin
            vld = 1'b1;
            dat = 8'hFF;
            @(negedge clk);
        end
        vld = 1'b0;
        chk("full_halt_ignored_writes", wr_b.size(), 0);
        chk("full_word_count", b.word_count, 4);
        chk("full_cpu_enable", b.cpu_enable, 0);
        chk("full_error_held", b.error, 1);
        sel = 1'b0;
        // reset part-way through a word discards the partial bytes
        do_reset(0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b0;
        vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send_word(32'hDDCC_BBAA, 0);
        vld = 1'b0;
        repeat (3) @(negedge clk);
        exp_write_a(8'd0, 32'hDDCC_BBAA);
        chk("mid_extra_writes", wr_a.size(), 0);
        chk("mid_word_count", a.word_count, 1);
        chk("mid_load_done", a.load_done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
